usb_dir_scheduler: RTL and testbench
====================================

USB_DIR_SCHEDULER -- requirements
Module: usb_dir_scheduler

Interface
REQ-001 SHALL have parameter BURST_MAX, default 64, meaning maximum bytes per direction grant (legal range 1..255).
REQ-002 SHALL have parameter TURN_CYCLES, default 2, meaning idle cycles forced between grants (legal range 1..15).
REQ-003 SHALL have port clk60  in  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RXFn  in  1  FT232H RX data available, active-low.
REQ-006 SHALL have port TXEn  in  1  FT232H TX space available, active-low.
REQ-007 SHALL have port in_wrfull  in  1  FPGA-bound FIFO full.
REQ-008 SHALL have port out_rdempty  in  1  PC-bound FIFO empty.
REQ-009 SHALL have port rx_strobe  in  1  one pulse per byte moved from FT232H into the FPGA-bound FIFO.
REQ-010 SHALL have port tx_strobe  in  1  one pulse per byte moved from the PC-bound FIFO to FT232H.
REQ-011 SHALL have port CMD  out  2  interface command: 00 idle, 01 read, 10 write; 11 never driven.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port rd_bursts  out  16  count of completed read grants.
REQ-014 SHALL have port wr_bursts  out  16  count of completed write grants.

Function
REQ-015 SHALL implement states IDLE, RD, WR and TURN; CMD SHALL be 01 only in RD, 10 only in WR, and 00 otherwise; CMD SHALL be a registered output.
REQ-016 SHALL define rx_ok = ~RXFn & ~in_wrfull and tx_ok = ~TXEn & ~out_rdempty, both sampled in IDLE.
REQ-017 SHALL move from IDLE to RD when only rx_ok is true, or to WR when only tx_ok is true; the new CMD SHALL appear one cycle after the sampling edge.
REQ-018 SHALL, when rx_ok and tx_ok are both true, grant the direction opposite to last_dir; last_dir SHALL update on each grant.
REQ-019 SHALL keep an 8-bit byte counter that clears on entry to RD or WR and increments on rx_strobe in RD or on tx_strobe in WR.
REQ-020 SHALL leave RD for TURN on the first of these: the counter reaching BURST_MAX (including the edge where the strobe makes it BURST_MAX), RXFn=1, or in_wrfull=1.
REQ-021 SHALL leave WR for TURN on the first of these: the counter reaching BURST_MAX, TXEn=1, or out_rdempty=1.
REQ-022 SHALL hold TURN for exactly TURN_CYCLES cycles with CMD=00, then return to IDLE.
REQ-023 SHALL ignore strobes received in IDLE or TURN, and SHALL ignore a strobe of the direction not currently granted.
REQ-024 SHALL ignore the strobe that arrives on the same edge as an exit condition, so the counter does not carry over into the next grant.
REQ-025 SHALL, when neither rx_ok nor tx_ok is true, remain in IDLE with CMD=00 indefinitely.

Reset
REQ-026 SHALL, while RST=1, force state=IDLE, CMD=00, busy=0, counter=0, rd_bursts=0 and wr_bursts=0, with last_dir set to write so that the first contested grant is a read.
REQ-027 SHALL, if RST asserts mid-burst, drop CMD to 00 asynchronously with no TURN phase; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-028 SHALL use macro USB_SCHED_STATS_EN: when it is defined, rd_bursts and wr_bursts SHALL increment, saturating at 16'hFFFF, on each RD->TURN and WR->TURN transition respectively.
REQ-029 SHALL, when USB_SCHED_STATS_EN is not defined, tie rd_bursts and wr_bursts to 0 and build no counters; the port list SHALL be identical in both builds.

Verification
REQ-030 SHALL test read cap: RXFn=0, TXEn=1, 300 rx_strobes at one per cycle -> CMD=01 for 64-byte grants separated by exactly 2 idle cycles; rd_bursts=5 after 300 bytes (stats build).
REQ-031 SHALL test alternation: rx_ok and tx_ok both held true -> grants alternate RD, WR, RD, ..., with the first grant RD after reset.
REQ-032 SHALL test early exit: in WR, out_rdempty rises after 10 tx_strobes -> TURN on the next edge, CMD=00 for 2 cycles, then IDLE.
REQ-033 SHALL test boundary strobe: BURST_MAX=4 with a strobe on the exit edge -> counter is 0 on the next grant and exactly 4 bytes are counted.
REQ-034 SHALL test reset mid-burst: RST pulsed during RD -> CMD=00 immediately, burst counters=0, and the next contested grant is RD.
REQ-035 SHALL test non-stats build: same stimulus as REQ-030 -> rd_bursts=wr_bursts=0 throughout while CMD behaviour is identical.

Source files
------------

// File: rtl/usb_dir_scheduler.sv
// FT232H synchronous-FIFO direction scheduler: grants read or write bursts with a forced turnaround gap.
// Optional burst statistics counters are built when USB_SCHED_STATS_EN is defined.
module usb_dir_scheduler #(
  parameter int unsigned BURST_MAX   = 64,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic        clk60,
  input  logic        RST,
  input  logic        RXFn,
  input  logic        TXEn,
  input  logic        in_wrfull,
  input  logic        out_rdempty,
  input  logic        rx_strobe,
  input  logic        tx_strobe,
  output logic [1:0]  CMD,
  output logic        busy,
  output logic [15:0] rd_bursts,
  output logic [15:0] wr_bursts
);

  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  state_t      state, state_d;
  logic [7:0]  byte_cnt;
  logic [3:0]  turn_cnt;
  logic        last_dir_wr;
  logic [1:0]  cmd_d;
  logic        busy_d;

  logic        rx_ok, tx_ok;
  logic        rd_flag_stop, wr_flag_stop;
  logic        rd_take, wr_take;
  logic [8:0]  rd_sum, wr_sum;
  logic        rd_stop, wr_stop;

  assign rx_ok = ~RXFn & ~in_wrfull;
  assign tx_ok = ~TXEn & ~out_rdempty;

  // A strobe coinciding with a flag exit is dropped; one that lands the count on the cap is kept.
  assign rd_flag_stop = RXFn | in_wrfull;
  assign wr_flag_stop = TXEn | out_rdempty;
  assign rd_take      = rx_strobe & ~rd_flag_stop;
  assign wr_take      = tx_strobe & ~wr_flag_stop;
  assign rd_sum       = {1'b0, byte_cnt} + {8'd0, rd_take};
  assign wr_sum       = {1'b0, byte_cnt} + {8'd0, wr_take};
  assign rd_stop      = rd_flag_stop | (rd_sum >= {1'b0, BURST_LIM});
  assign wr_stop      = wr_flag_stop | (wr_sum >= {1'b0, BURST_LIM});

  // NOTE: every register uses non-blocking assignment and an asynchronous reset clause, so
  // all flops update together on the edge and reset without waiting for the clock.
  always_ff @(posedge clk60 or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rx_ok && (!tx_ok || last_dir_wr)) state_d = RD;
        else if (tx_ok)                       state_d = WR;
      end
      RD:      if (rd_stop) state_d = TURN;
      WR:      if (wr_stop) state_d = TURN;
      TURN:    if (turn_cnt == TURN_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CMD and busy are decoded from the next state and registered, so they track state exactly.
  always_comb begin
    cmd_d  = CMD_IDLE;
    busy_d = (state_d != IDLE);
    case (state_d)
      RD:      cmd_d = CMD_READ;
      WR:      cmd_d = CMD_WRITE;
      default: cmd_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk60 or posedge RST) begin
    if (RST) begin
      CMD  <= CMD_IDLE;
      busy <= 1'b0;
    end else begin
      CMD  <= cmd_d;
      busy <= busy_d;
    end
  end

  always_ff @(posedge clk60 or posedge RST) begin
    if (RST) begin
      byte_cnt    <= 8'd0;
      turn_cnt    <= 4'd0;
      last_dir_wr <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (state_d == RD) begin
            byte_cnt    <= 8'd0;
            last_dir_wr <= 1'b0;
          end else if (state_d == WR) begin
            byte_cnt    <= 8'd0;
            last_dir_wr <= 1'b1;
          end
        end
        RD: begin
          turn_cnt <= 4'd0;
          if (rd_take) byte_cnt <= rd_sum[7:0];
        end
        WR: begin
          turn_cnt <= 4'd0;
          if (wr_take) byte_cnt <= wr_sum[7:0];
        end
        TURN:    turn_cnt <= turn_cnt + 4'd1;
        default: turn_cnt <= 4'd0;
      endcase
    end
  end

`ifdef USB_SCHED_STATS_EN
  always_ff @(posedge clk60 or posedge RST) begin
    if (RST) begin
      rd_bursts <= 16'd0;
      wr_bursts <= 16'd0;
    end else begin
      if (state == RD && state_d == TURN && rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
      if (state == WR && state_d == TURN && wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
    end
  end
`else
  assign rd_bursts = 16'd0;
  assign wr_bursts = 16'd0;
`endif

endmodule

// File: tb/tb_usb_dir_scheduler.sv
// Directed bench for usb_dir_scheduler: read cap, early exit, reset mid-burst, alternation, boundary strobe.
module tb_usb_dir_scheduler;

`ifdef USB_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk60 = 1'b0;
  logic rst;
  logic rxfn, txen, wrfull, rdempty, rxs, txs;
  logic [1:0]  cmd;
  logic        busy;
  logic [15:0] rdb, wrb;

  logic rxfn4, txen4, rxs4;
  logic [1:0]  cmd4;
  logic        busy4;
  logic [15:0] rdb4, wrb4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk60 = ~clk60;

  usb_dir_scheduler dut (
    .clk60(clk60), .RST(rst), .RXFn(rxfn), .TXEn(txen),
    .in_wrfull(wrfull), .out_rdempty(rdempty),
    .rx_strobe(rxs), .tx_strobe(txs),
    .CMD(cmd), .busy(busy), .rd_bursts(rdb), .wr_bursts(wrb)
  );

  usb_dir_scheduler #(.BURST_MAX(4), .TURN_CYCLES(2)) dut4 (
    .clk60(clk60), .RST(rst), .RXFn(rxfn4), .TXEn(txen4),
    .in_wrfull(1'b0), .out_rdempty(1'b0),
    .rx_strobe(rxs4), .tx_strobe(1'b0),
    .CMD(cmd4), .busy(busy4), .rd_bursts(rdb4), .wr_bursts(wrb4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk60);
    @(negedge clk60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[$];
    int turns[$];
    logic [1:0] grants[$];
    logic [1:0] prev;
    int run, tcnt, sent, ncyc;
    bit bad;

    rst = 1'b1; rxfn = 1'b1; txen = 1'b1; wrfull = 1'b0; rdempty = 1'b1;
    rxs = 1'b0; txs = 1'b0; rxfn4 = 1'b1; txen4 = 1'b1; rxs4 = 1'b0;
    tick; tick;
    check("rst_cmd",      32'(cmd), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_rdb",      32'(rdb), 0);
    check("rst_wrb",      32'(wrb), 0);
    check("rst_cnt",      32'(dut.byte_cnt), 0);
    check("rst_last_dir", 32'(dut.last_dir_wr), 1);
    rst = 1'b0;
    tick; tick; tick;
    check("idle_cmd",  32'(cmd), 0);
    check("idle_busy", 32'(busy), 0);

    // Read cap: 300 bytes through 64-byte grants.
    run = 0; tcnt = 0; sent = 0; bad = 1'b0;
    rxfn = 1'b0;
    for (int c = 0; c < 420; c++) begin
      if (cmd == 2'b01) run++;
      else if (run > 0) begin lens.push_back(run); run = 0; end
      if (busy && cmd == 2'b00) tcnt++;
      else if (tcnt > 0) begin turns.push_back(tcnt); tcnt = 0; end
      if (cmd[1]) bad = 1'b1;
      if (cmd == 2'b01 && sent < 300) begin rxs = 1'b1; sent++; end
      else begin rxs = 1'b0; if (sent == 300) rxfn = 1'b1; end
      tick;
    end
    check("rdcap_grants", lens.size(), 5);
    for (int i = 0; i < 4; i++)
      check($sformatf("rdcap_len%0d", i), (i < lens.size()) ? lens[i] : 0, 64);
    check("rdcap_len_last", (lens.size() > 4) ? lens[4] : 0, 45);
    check("rdcap_turns", turns.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("rdcap_turn%0d", i), (i < turns.size()) ? turns[i] : 0, 2);
    check("rdcap_no_wr", 32'(bad), 0);
    check("rdcap_rdb", 32'(rdb), 5 * STATS);
    check("rdcap_wrb", 32'(wrb), 0);

    // Early exit from WR when the PC-bound FIFO empties after 10 bytes.
    txen = 1'b0; rdempty = 1'b0;
    for (int i = 0; i < 20 && cmd != 2'b10; i++) tick;
    check("early_grant", 32'(cmd), 2);
    for (int i = 0; i < 10; i++) begin txs = 1'b1; tick; end
    check("early_pre_cmd", 32'(cmd), 2);
    check("early_cnt", 32'(dut.byte_cnt), 10);
    txs = 1'b0; rdempty = 1'b1;
    tick;
    check("early_turn1_cmd",  32'(cmd), 0);
    check("early_turn1_busy", 32'(busy), 1);
    tick;
    check("early_turn2_cmd",  32'(cmd), 0);
    check("early_turn2_busy", 32'(busy), 1);
    tick;
    check("early_idle_busy", 32'(busy), 0);
    tick; tick; tick;
    check("early_stay_cmd",  32'(cmd), 0);
    check("early_stay_busy", 32'(busy), 0);
    check("early_wrb", 32'(wrb), STATS);

    // Reset asserted mid-read; last grant was RD so only reset makes the next contested grant RD.
    rxfn = 1'b0;
    for (int i = 0; i < 20 && cmd != 2'b01; i++) tick;
    check("rstmid_grant", 32'(cmd), 1);
    rxs = 1'b1; tick; tick;
    #2 rst = 1'b1;
    #1;
    check("rstmid_cmd",  32'(cmd), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_rdb",  32'(rdb), 0);
    check("rstmid_wrb",  32'(wrb), 0);
    check("rstmid_cnt",  32'(dut.byte_cnt), 0);
    @(negedge clk60);
    rxs = 1'b0; rst = 1'b0;

    // Alternation with both directions ready.
    txen = 1'b0; rdempty = 1'b0; rxfn = 1'b0; wrfull = 1'b0;
    prev = 2'b00; ncyc = 0;
    while (grants.size() < 4 && ncyc < 600) begin
      if (cmd != 2'b00 && prev == 2'b00) grants.push_back(cmd);
      prev = cmd;
      rxs = (cmd == 2'b01);
      txs = (cmd == 2'b10);
      if (grants.size() < 4) begin tick; ncyc++; end
    end
    check("alt_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 0,
            (i % 2 == 0) ? 1 : 2);
    check("alt_rdb", 32'(rdb), 2 * STATS);
    check("alt_wrb", 32'(wrb), STATS);
    rxs = 1'b0; txs = 1'b0; rxfn = 1'b1; txen = 1'b1;

    // Boundary strobe on a 4-byte cap, then a strobe dropped on a flag exit.
    rxfn4 = 1'b0; rxs4 = 1'b1;
    for (int i = 0; i < 20 && cmd4 != 2'b01; i++) tick;
    check("bnd_grant", 32'(cmd4), 1);
    check("bnd_entry_cnt", 32'(dut4.byte_cnt), 0);
    ncyc = 0;
    while (cmd4 == 2'b01 && ncyc < 20) begin ncyc++; tick; end
    check("bnd_rd_cycles", ncyc, 4);
    check("bnd_turn_busy", 32'(busy4), 1);
    check("bnd_turn_cnt", 32'(dut4.byte_cnt), 4);
    tick;
    check("bnd_turn_hold_cnt", 32'(dut4.byte_cnt), 4);
    for (int i = 0; i < 20 && cmd4 != 2'b01; i++) tick;
    check("bnd_regrant", 32'(cmd4), 1);
    check("bnd_regrant_cnt", 32'(dut4.byte_cnt), 0);
    tick; tick;
    check("bnd_two_cnt", 32'(dut4.byte_cnt), 2);
    rxfn4 = 1'b1;
    tick;
    check("bnd_flag_cmd", 32'(cmd4), 0);
    check("bnd_flag_cnt", 32'(dut4.byte_cnt), 2);
    check("bnd_rdb", 32'(rdb4), 2 * STATS);
    rxs4 = 1'b0;
    tick; tick; tick;
    check("bnd_idle_busy", 32'(busy4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
